// File: rtl/imem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | imem_pkg : shared constants and loader state encoding for imem_*       |
// | Rev 1.0  : initial release                                             |
// +-----------------------------------------------------------------------+
package imem_pkg;

  localparam int unsigned NOP_W = 64;
  localparam logic [NOP_W-1:0] NOP_WORD = '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DRAIN   = 3'd2,
    RELEASE = 3'd3,
    ERR     = 3'd4
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_prog_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | imem_prog_loader_if : program-load request and word stream             |
// | Rev 1.0  : initial release                                             |
// +-----------------------------------------------------------------------+
interface imem_prog_loader_if #(
  parameter int DATA_W = 16
);
  logic              load_start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;

  modport master (output load_start, s_valid, s_data, s_last, input  s_ready);
  modport slave  (input  load_start, s_valid, s_data, s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | imem_array : DEPTH x DATA_W storage, sync write, async read, no reset  |
// | Rev 1.0  : initial release                                             |
// +-----------------------------------------------------------------------+
module imem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/imem_prog_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | imem_prog_loader : instruction memory with runtime program-load port;  |
// | optional XOR checksum trailer enabled by IMEM_CHECKSUM_EN              |
// | Rev 1.0  : initial release                                             |
// +-----------------------------------------------------------------------+
module imem_prog_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int PC_W   = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  imem_prog_loader_if.slave  ld,
  input  logic [PC_W-1:0]    fetch_addr,
  output logic [DATA_W-1:0]  fetch_data,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W:0]    load_count
);

  loader_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_err, r_done;
  logic              w_xfer, w_start, w_store, w_set_err;
  logic [DATA_W-1:0] w_rd_data;
`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  assign ld.s_ready = (r_state == LOAD) || (r_state == DRAIN);
  assign cpu_hold   = (r_state != IDLE);
  assign w_xfer     = ld.s_valid & ld.s_ready;
  assign w_start    = ld.load_start && ((r_state == IDLE) || (r_state == ERR));

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      IDLE, ERR: if (w_start) w_state_nxt = LOAD;
      LOAD: begin
        if (w_xfer) begin
          if (ld.s_last) begin
`ifdef IMEM_CHECKSUM_EN
            // trailer word is the checksum, never stored
            if (r_csum == ld.s_data) begin
              w_state_nxt = RELEASE;
            end else begin
              w_state_nxt = ERR;
              w_set_err   = 1'b1;
            end
`else
            w_store     = 1'b1;
            w_state_nxt = RELEASE;
`endif
          end else begin
            w_store = 1'b1;
            if (r_ptr == ADDR_W'(DEPTH - 1)) begin
              w_state_nxt = DRAIN;
              w_set_err   = 1'b1;
            end
          end
        end
      end
      DRAIN:   if (w_xfer && ld.s_last) w_state_nxt = ERR;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == RELEASE);
      if (w_start) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_store) begin
          r_ptr   <= r_ptr + 1'b1;
          r_count <= r_count + 1'b1;
        end
        if (w_set_err) r_err <= 1'b1;
      end
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_store) r_csum <= r_csum ^ ld.s_data;
  end
`endif

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (CLK),
    .i_we    (w_store),
    .i_waddr (r_ptr),
    .i_wdata (ld.s_data),
    .i_raddr (fetch_addr[ADDR_W-1:0]),
    .o_rdata (w_rd_data)
  );

  // the CPU sees NOPs while held or when running off the end of memory
  assign fetch_data = (!cpu_hold && (fetch_addr < PC_W'(DEPTH))) ? w_rd_data
                                                                 : NOP_WORD[DATA_W-1:0];
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign load_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_prog_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_imem_prog_loader : self-checking bench for imem_prog_loader         |
// | Rev 1.0  : initial release                                             |
// +-----------------------------------------------------------------------+
module tb_imem_prog_loader;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int PC_W   = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [PC_W-1:0]   fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_hold, load_done, load_err;
  logic [ADDR_W:0]   load_count;

  imem_prog_loader_if #(.DATA_W(DATA_W)) ld_if ();

  imem_prog_loader #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ld         (ld_if),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .load_count (load_count)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] tx [64];
  logic [15:0] mm [DEPTH];
  bit          mk [DEPTH];

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp;
  } fvec_t;
  fvec_t ftab [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Transaction-level view: n words arrive, last one flagged. Updates model memory.
  function automatic void model_load(input int n, output bit err, output int cnt);
    int pay;
`ifdef IMEM_CHECKSUM_EN
    logic [15:0] x;
    pay = n - 1;
`else
    pay = n;
`endif
    err = (n - 1 >= DEPTH);
    cnt = (pay > DEPTH) ? DEPTH : pay;
    for (int i = 0; i < cnt; i++) begin
      mm[i] = tx[i];
      mk[i] = 1'b1;
    end
`ifdef IMEM_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < cnt; i++) x ^= tx[i];
    if (!err && (x != tx[n-1])) err = 1'b1;
`endif
  endfunction

  task automatic check_mem(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      if (mk[a]) begin
        fetch_addr = 16'(a);
        #1;
        chk($sformatf("%s mem[%0d]", tag, a), 32'(fetch_data), 32'(mm[a]));
      end
    end
    fetch_addr = 16'(DEPTH);
    #1;
    chk({tag, " oob depth"}, 32'(fetch_data), 32'h0);
    fetch_addr = 16'hFFFF;
    #1;
    chk({tag, " oob ffff"}, 32'(fetch_data), 32'h0);
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_ftab(input string tag);
    for (int i = 0; i < 20; i++) begin
      fetch_addr = ftab[i].addr;
      #1;
      chk($sformatf("%s ftab[%0d]", tag, i), 32'(fetch_data), 32'(ftab[i].exp));
    end
    @(posedge CLK);
    #1;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before each word, 2 random idles
  task automatic run_load(input int n, input int gap_mode, input string tag);
    bit exp_err;
    int exp_cnt;
    bit hold_ok;
    bit stuck;
    int idle;
    int w;
    model_load(n, exp_err, exp_cnt);
    ld_if.load_start = 1'b1;
    step();
    ld_if.load_start = 1'b0;
    chk({tag, " start s_ready"}, 32'(ld_if.s_ready), 32'h1);
    chk({tag, " start hold"},    32'(cpu_hold),      32'h1);
    chk({tag, " start err"},     32'(load_err),      32'h0);
    chk({tag, " start count"},   32'(load_count),    32'h0);
    hold_ok = 1'b1;
    stuck   = 1'b0;
    for (int i = 0; i < n && !stuck; i++) begin
      idle = 0;
      if (gap_mode == 1) idle = 1;
      else if (gap_mode == 2 && ($urandom % 3 == 0)) idle = $urandom_range(1, 2);
      for (int k = 0; k < idle; k++) begin
        ld_if.s_valid    = 1'b0;
        ld_if.s_data     = 16'($urandom);
        ld_if.s_last     = 1'($urandom);
        ld_if.load_start = (k == 0) && (i == n / 2);
        if (cpu_hold !== 1'b1) hold_ok = 1'b0;
        step();
        ld_if.load_start = 1'b0;
      end
      ld_if.s_valid = 1'b1;
      ld_if.s_data  = tx[i];
      ld_if.s_last  = (i == n - 1);
      w = 0;
      while (ld_if.s_ready !== 1'b1 && w < 4) begin
        step();
        w++;
      end
      if (ld_if.s_ready !== 1'b1) begin
        chk($sformatf("%s s_ready word %0d", tag, i), 32'(ld_if.s_ready), 32'h1);
        stuck = 1'b1;
      end else begin
        if (cpu_hold !== 1'b1) hold_ok = 1'b0;
        step();
      end
    end
    ld_if.s_valid = 1'b0;
    ld_if.s_last  = 1'b0;
    chk({tag, " hold during load"}, 32'(hold_ok), 32'h1);
    // one cycle after the final word
    chk({tag, " n+1 hold"},    32'(cpu_hold),      32'h1);
    chk({tag, " n+1 s_ready"}, 32'(ld_if.s_ready), 32'h0);
    chk({tag, " n+1 done"},    32'(load_done),     32'h0);
    chk({tag, " n+1 err"},     32'(load_err),      32'(exp_err));
    step();
    chk({tag, " n+2 hold"},    32'(cpu_hold),      32'(exp_err));
    chk({tag, " n+2 done"},    32'(load_done),     32'(!exp_err));
    chk({tag, " n+2 err"},     32'(load_err),      32'(exp_err));
    chk({tag, " n+2 count"},   32'(load_count),    32'(exp_cnt));
    chk({tag, " n+2 s_ready"}, 32'(ld_if.s_ready), 32'h0);
    step();
    chk({tag, " n+3 done"},    32'(load_done),     32'h0);
    chk({tag, " n+3 hold"},    32'(cpu_hold),      32'(exp_err));
    if (!exp_err) check_mem(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n17;
    ld_if.load_start = 1'b0;
    ld_if.s_valid    = 1'b0;
    ld_if.s_data     = '0;
    ld_if.s_last     = 1'b0;
    fetch_addr       = 16'd40;
    for (int i = 0; i < DEPTH; i++) mk[i] = 1'b0;

    for (int i = 0; i < 17; i++) begin
      ftab[i].addr = 16'(i);
      ftab[i].exp  = (i == 0) ? 16'h4C00 : (i == 16) ? 16'h4CA0 : 16'h5400 + 16'(i);
    end
    ftab[17] = '{16'd32,   16'h0000};
    ftab[18] = '{16'd40,   16'h0000};
    ftab[19] = '{16'hFFFF, 16'h0000};

    repeat (2) @(posedge CLK);
    #1;
    chk("reset s_ready", 32'(ld_if.s_ready), 32'h0);
    chk("reset hold",    32'(cpu_hold),      32'h0);
    chk("reset err",     32'(load_err),      32'h0);
    chk("reset done",    32'(load_done),     32'h0);
    chk("reset count",   32'(load_count),    32'h0);
    chk("reset fetch40", 32'(fetch_data),    32'h0);
    RST = 1'b1;
    step();

    // 17-word program
    for (int i = 0; i < 17; i++)
      tx[i] = (i == 0) ? 16'h4C00 : (i == 16) ? 16'h4CA0 : 16'h5400 + 16'(i);
    n17 = 17;
`ifdef IMEM_CHECKSUM_EN
    tx[17] = '0;
    for (int i = 0; i < 17; i++) tx[17] ^= tx[i];
    n17 = 18;
`endif
    run_load(n17, 0, "b2b");
    chk("b2b count17", 32'(load_count), 32'd17);
    apply_ftab("b2b");
    run_load(n17, 1, "toggle");
    chk("toggle count17", 32'(load_count), 32'd17);
    apply_ftab("toggle");

    // overflow: 32 words without last, then 3 more ending with last
    for (int i = 0; i < 32; i++) tx[i] = 16'h1000 + 16'(i);
    for (int i = 32; i < 35; i++) tx[i] = 16'hEEE0 + 16'(i);
    run_load(35, 0, "ovf");
    chk("ovf count", 32'(load_count),    32'd32);
    chk("ovf err",   32'(load_err),      32'h1);
    chk("ovf hold",  32'(cpu_hold),      32'h1);
    chk("ovf ready", 32'(ld_if.s_ready), 32'h0);
    fetch_addr = 16'd1;
    #1;
    chk("ovf fetch held nop", 32'(fetch_data), 32'h0);
    step();
`ifdef IMEM_CHECKSUM_EN
    tx[0] = 16'h0000;
`else
    tx[0] = 16'hABCD;
`endif
    run_load(1, 0, "after_ovf");

    // asynchronous reset in the middle of a load
    for (int i = 0; i < 5; i++) tx[i] = 16'h7700 + 16'(i);
    ld_if.load_start = 1'b1;
    step();
    ld_if.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_if.s_valid = 1'b1;
      ld_if.s_data  = tx[i];
      ld_if.s_last  = 1'b0;
      step();
    end
    ld_if.s_valid = 1'b0;
    #3;
    RST = 1'b0;
    #1;
    chk("midrst hold",  32'(cpu_hold),      32'h0);
    chk("midrst ready", 32'(ld_if.s_ready), 32'h0);
    chk("midrst count", 32'(load_count),    32'h0);
    chk("midrst err",   32'(load_err),      32'h0);
    chk("midrst done",  32'(load_done),     32'h0);
    for (int i = 0; i < 5; i++) begin
      mm[i] = tx[i];
      mk[i] = 1'b1;
    end
    step();
    step();
    RST = 1'b1;
    step();
    check_mem("midrst");

`ifdef IMEM_CHECKSUM_EN
    tx[0] = 16'h0001; tx[1] = 16'h0002; tx[2] = 16'h0003;
    run_load(3, 0, "csum_ok");
    chk("csum_ok count", 32'(load_count), 32'd2);
    tx[2] = 16'h0004;
    run_load(3, 0, "csum_bad");
    chk("csum_bad err",  32'(load_err), 32'h1);
    chk("csum_bad hold", 32'(cpu_hold), 32'h1);
`endif

    // randomized loads, including exactly-full and one-over
    for (int t = 0; t < 20; t++) begin
      int n;
      n = (t == 3) ? DEPTH : (t == 7) ? DEPTH + 1 : $urandom_range(1, 40);
      for (int i = 0; i < n; i++) tx[i] = 16'($urandom);
`ifdef IMEM_CHECKSUM_EN
      if ($urandom % 4 != 0) begin
        tx[n-1] = '0;
        for (int i = 0; i < n - 1; i++) tx[n-1] ^= tx[i];
      end
`endif
      run_load(n, 2, $sformatf("rnd%0d", t));
    end

    tx[0] = 16'h0000;
    run_load(1, 0, "final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Parametrised instruction memory with a runtime program-load port for the single-cycle CPU top. It replaces forcing memory words from the bench.
- A valid/ready word stream fills the memory while the CPU is held. The CPU fetch port returns a NOP word until the load completes, then normal fetching resumes.
- Sits between the top-level load source (bench or UART bridge) and the CPU fetch stage.

Parameters:
- DATA_W, 16, instruction word width
- DEPTH, 32, number of memory words
- PC_W, 16, width of the CPU fetch address
- ADDR_W, $clog2(DEPTH), internal write pointer width

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset (RST=0 resets)
- load_start  in  1  one-cycle request to begin a program load
- s_valid  in  1  load word valid
- s_data  in  DATA_W  load word
- s_last  in  1  marks final word of the load stream
- s_ready  out  1  loader accepts a word this cycle
- fetch_addr  in  PC_W  CPU program counter (word address)
- fetch_data  out  DATA_W  instruction at fetch_addr (combinational read)
- cpu_hold  out  1  CPU must stall/hold PC while high
- load_done  out  1  one-cycle pulse on successful completion
- load_err  out  1  sticky error flag, cleared by next accepted load_start
- load_count  out  ADDR_W+1  words stored by the current/last load

Behaviour:
- Reset (RST=0, async):
  - FSM=IDLE; s_ready=0, cpu_hold=0, load_done=0, load_err=0, load_count=0, write pointer=0.
  - Memory array is not reset.
- fetch_data is combinational and equals mem[fetch_addr] when all of these hold:
  - cpu_hold=0
  - fetch_addr<DEPTH
  - otherwise it equals NOP_WORD (all zeros).
- FSM states: IDLE, LOAD, DRAIN, RELEASE, ERR.
- IDLE / ERR:
  - load_start=1 → LOAD next cycle; pointer=0, load_count=0, load_err=0.
  - load_start while in LOAD, DRAIN or RELEASE is ignored.
- LOAD:
  - cpu_hold=1, s_ready=1.
  - A transfer occurs when s_valid&s_ready: mem[ptr]<=s_data, ptr++, load_count++.
  - Transfer with s_last=1 → RELEASE.
  - Transfer at ptr==DEPTH-1 with s_last=0 → DRAIN, load_err<=1 (overflow).
  - No transfer → stay, no change.
- DRAIN:
  - cpu_hold=1, s_ready=1.
  - Words are discarded; memory and load_count are unchanged.
  - Transfer with s_last=1 → ERR.
- RELEASE:
  - cpu_hold=1 and s_ready=0 for exactly one cycle, then → IDLE.
  - load_done pulses for 1 cycle on the RELEASE→IDLE edge, i.e. load_done=1 in the first IDLE cycle.
  - cpu_hold=0 from that same cycle.
- ERR: cpu_hold stays 1 and s_ready=0 until the next load_start.
- Latency: last word accepted at cycle N → cpu_hold falls and load_done=1 at cycle N+2.
- s_last on the DEPTH-th word is a legal full load, with no error.
- Reset mid-load: immediate return to IDLE with cpu_hold=0. Partially written memory is kept.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- Defined:
  - The word transferred with s_last=1 is an XOR checksum and is not stored or counted.
  - The loader accumulates the XOR of all stored words; accumulator resets on load_start.
  - Match → RELEASE.
  - Mismatch → ERR with load_err=1.
  - An empty payload (first word has s_last) checks against 0.
- Undefined: the s_last word is ordinary data and is stored; there is no checksum logic.

Decomposition:
- Package imem_pkg holds:
  - NOP_WORD constant
  - loader state enum typedef (IDLE, LOAD, DRAIN, RELEASE, ERR)
- One sub-module: imem_array. It is the DEPTH×DATA_W storage with one synchronous write port and one combinational read port, without reset.
- The FSM, pointer, counters and checksum stay in imem_prog_loader.

Test Plan:
- Reset with RST=0 → s_ready=0, cpu_hold=0, load_err=0, load_count=0; fetch_addr=40 (≥DEPTH) → fetch_data=0x0000.
- load_start, then 17 words 0x4C00,0x5401,…,0x4CA0 back-to-back, last with s_last → cpu_hold=1 throughout.
  - load_done pulses 2 cycles after last word; load_count=17.
  - fetch_addr=0 → 0x4C00; fetch_addr=16 → 0x4CA0.
- Same load with s_valid toggling every other cycle → identical memory contents; writes occur only on valid&ready.
- load_start then 32 words without s_last, then 3 more with s_last on the third → load_err=1 and ERR state, cpu_hold=1.
  - load_count=32; extra words not written.
  - A new load_start clears load_err.
- RST=0 asserted after 5 words of a load → outputs at reset values immediately; mem[0..4] retain the loaded words.
- With IMEM_CHECKSUM_EN: words 0x0001,0x0002, checksum 0x0003 → load_done, load_count=2. Checksum 0x0004 instead → load_err=1, cpu_hold stays 1.
